mux_rr_arbiter: RTL

Round-robin arbiter that shares one 4:1 bit multiplexer between four requesters.
- Grants one requester at a time and drives the mux select.
- Enforces a per-grant beat limit so one source cannot hold the output.
- Qualifies the muxed bit with a valid/ready handshake toward the downstream consumer.
- Sits between four single-bit sources (a..d) and one shared serial output channel.

---
 rtl/mux_arb_pkg.sv | 22 ++
 rtl/mux_rr_arbiter_rr_pick.sv | 28 ++
 rtl/mux_rr_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
// Imported by the picker and the top level.
package mux_arb_pkg;

  localparam int REQ_N = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  function automatic logic [REQ_N-1:0] onehot(
    input logic [SEL_W-1:0] s
  );
    logic [REQ_N-1:0] v;
    v = '0;
    v[s] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Rotating priority encoder: first set req bit after last_ptr wins.
// Purely combinational, wraps from REQ_N-1 back to 0.
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [REQ_N-1:0] req,
  input  logic [SEL_W-1:0] last_ptr,
  output logic             any,
  output logic [SEL_W-1:0] winner
);

  logic [SEL_W-1:0] idx;

  // Descending scan so the nearest candidate is written last and wins.
  always_comb begin
    any    = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = REQ_N - 1; i >= 0; i--) begin
      idx = last_ptr + SEL_W'(i + 1);
      if (req[idx]) begin
        any    = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing a 4:1 bit mux between four sources,
// with a per-grant beat limit and valid/ready toward the consumer.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int               HOLD_MAX = 4,
  parameter logic [SEL_W-1:0] IDLE_SEL = 2'b00
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REQ_N-1:0] req,
  input  logic [REQ_N-1:0] data_in,
  input  logic             out_ready,
  output logic [SEL_W-1:0] sel,
  output logic [REQ_N-1:0] grant,
  output logic             out,
  output logic             out_valid,
  output logic             busy
);

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_MAX - 1);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [REQ_N-1:0] grant_q, grant_d;
  logic [SEL_W-1:0] last_ptr_q, last_ptr_d;
  logic [3:0]       beat_cnt_q, beat_cnt_d;

  logic [REQ_N-1:0] pick_req;
  logic [SEL_W-1:0] pick_ptr;
  logic             pick_any;
  logic [SEL_W-1:0] pick_win;
  logic             beat;
  logic             rel;

  assign sel       = sel_q;
  assign grant     = grant_q;
  assign out       = data_in[sel_q];
  assign busy      = (state_q == GRANT);
  assign out_valid = busy && req[sel_q];
  assign beat      = out_valid && out_ready;
  assign rel       = !req[sel_q] ||
                     (beat && beat_cnt_q == HOLD_LAST);

  // While granted, the holder is masked out so others get first chance.
  always_comb begin
    pick_req = req;
    pick_ptr = last_ptr_q;
    if (state_q == GRANT) begin
      pick_req = req & ~grant_q;
      pick_ptr = sel_q;
    end
  end

  rr_pick u_pick (
    .req      (pick_req),
    .last_ptr (pick_ptr),
    .any      (pick_any),
    .winner   (pick_win)
  );

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    grant_d    = grant_q;
    last_ptr_d = last_ptr_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d    = GRANT;
          sel_d      = pick_win;
          grant_d    = onehot(pick_win);
          beat_cnt_d = '0;
        end
      end
      GRANT: begin
        if (rel) begin
          last_ptr_d = sel_q;
          beat_cnt_d = '0;
          if (pick_any) begin
            sel_d   = pick_win;
            grant_d = onehot(pick_win);
          end else if (!req[sel_q]) begin
            state_d = IDLE;
            sel_d   = IDLE_SEL;
            grant_d = '0;
          end
        end else if (beat) begin
          beat_cnt_d = beat_cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = IDLE_SEL;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sel_q      <= IDLE_SEL;
      grant_q    <= '0;
      last_ptr_q <= 2'd3;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      grant_q    <= grant_d;
      last_ptr_q <= last_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule
